div_mse_accumulator: RTL and testbench
======================================

// Module: div_mse_accumulator
// PURPOSE
//  Downstream consumer of the 8-bit array divider (approximate and exact variants in parallel).
//  Takes per-sample quotient pairs (approx vs exact) and measures quotient error over a run of
//  2**LOG2_N samples: sum of squared error, mean squared error (MSE) and max absolute error.
//  Produces the MSE/delay figures of merit on chip, so simulation need not dump every sample.
// PARAMETERS
//  LOG2_N  8   log2 of samples per run; legal range 1..16
//  ACC_W   32  accumulator width in bits; must be >= 16+LOG2_N or saturation can occur
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  start      in   1      one-cycle pulse; arms a new run (honoured only in IDLE)
//  in_valid   in   1      sample present
//  in_ready   out  1      sample accepted when in_valid & in_ready
//  q_apx      in   8      quotient from the approximate divider
//  q_exact    in   8      quotient from the exact divider, same operands
//  d_zero     in   1      divisor was 0: sample consumed, not counted, not accumulated
//  res_valid  out  1      run result held
//  res_ready  in   1      result consumed when res_valid & res_ready
//  sse        out  ACC_W  sum of squared quotient error
//  mse        out  ACC_W  sse >> LOG2_N (truncating)
//  max_err    out  8      max |q_exact - q_apx| over the run
//  sat        out  1      sse saturated at all-ones during the run (sticky per run)
//  skip_cnt   out  16     count of d_zero samples; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=0, res_valid=0, sse=mse=0, max_err=0, sat=0, skip_cnt=0;
//    pipeline valids cleared. Reset mid-run abandons the run; no partial result.
//  FSM IDLE -> RUN on start; clears sse, max_err, sat, skip_cnt and both sample counters.
//  RUN: in_ready=1 while accepted-count < 2**LOG2_N; accepted-count counts non-d_zero samples.
//    d_zero samples are always accepted in RUN; they increment skip_cnt only.
//  Pipeline, T = accept cycle:
//    edge ending T: e = q_exact - q_apx (9-bit signed) and |e| registered.
//    edge ending T+1: sse += e*e (16-bit unsigned, zero-extended); max_err updated;
//      done-count++.
//  RUN -> DRAIN when accepted-count reaches 2**LOG2_N (in_ready=0 from the next cycle).
//  DRAIN -> DONE when done-count == 2**LOG2_N.
//    mse is registered on that edge; res_valid=1 from the next cycle.
//  Last-sample latency: res_valid rises in cycle T+3.
//  DONE: outputs stable while res_valid; res_valid & res_ready -> IDLE next cycle.
//    Outputs keep their values until the next start.
//  start outside IDLE is ignored, including start coinciding with the res_ready handshake.
//  Saturation: if sse + e*e overflows ACC_W, sse = all-ones and sat=1 for the rest of the run.
//  in_valid while in_ready=0 is not consumed; upstream must hold the sample.
// CONFIGURATION
//  DIV_MSE_REM_EN defined:
//    adds inputs r_apx[7:0] and r_exact[7:0], and outputs rem_sse[ACC_W-1:0] and rem_mse.
//    Remainder error uses the same pipeline, latency and saturation rules; shares sat.
//  DIV_MSE_REM_EN undefined: these ports and their logic are absent.
// TESTING
//  1. LOG2_N=2, start, 4 samples q_exact=q_apx=10
//     -> sse=0, mse=0, max_err=0, res_valid in cycle T_last+3.
//  2. LOG2_N=2, samples with errors +3,-3,+1,0
//     -> sse=19, mse=4, max_err=3, sat=0.
//  3. LOG2_N=1, in_valid continuous, d_zero=1 on 2nd of 3 samples
//     -> skip_cnt=1, result built from samples 1 and 3.
//  4. ACC_W=17, LOG2_N=2, 4 samples q_exact=255, q_apx=0
//     -> sat=1, sse=17'h1FFFF.
//  5. Hold res_ready=0 for 10 cycles
//     -> outputs stable, in_ready=0, start pulses ignored.
//     Then res_ready=1 -> IDLE, new start accepted.
//  6. Assert rst mid-RUN after 2 samples
//     -> all outputs at reset values next cycle, no res_valid.
//     Fresh run then completes correctly.

Source files
------------

// File: rtl/div_mse_accumulator.sv
// div_mse_accumulator
// Measures quotient error between an approximate and an exact 8-bit divider over
// runs of 2**LOG2_N samples: sum of squared error, MSE and max |error|.
// Optional feature macro: DIV_MSE_REM_EN adds a remainder-error path (rem_sse/rem_mse)
// that uses the same pipeline and shares the sticky saturation flag.
module div_mse_accumulator #(
  parameter int LOG2_N = 8,
  parameter int ACC_W  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [7:0]       i_q_apx,
  input  logic [7:0]       i_q_exact,
  input  logic             i_d_zero,
`ifdef DIV_MSE_REM_EN
  input  logic [7:0]       i_r_apx,
  input  logic [7:0]       i_r_exact,
  output logic [ACC_W-1:0] o_rem_sse,
  output logic [ACC_W-1:0] o_rem_mse,
`endif
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic [ACC_W-1:0] o_sse,
  output logic [ACC_W-1:0] o_mse,
  output logic [7:0]       o_max_err,
  output logic             o_sat,
  output logic [15:0]      o_skip_cnt
);

  localparam int CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ACC_W-1:0] ACC_ONES  = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] ACC_ZERO  = {ACC_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Signed 9-bit difference exact - apx (two's complement in 9 bits).
  function automatic logic [8:0] err9(input logic [7:0] exact, input logic [7:0] apx);
    return {1'b0, exact} - {1'b0, apx};
  endfunction

  // Magnitude of a 9-bit signed error; range is 0..255 so it fits 8 bits.
  function automatic logic [7:0] abs9(input logic [8:0] e);
    logic [7:0] neg;
    neg = ~e[7:0] + 8'd1;
    return e[8] ? neg : e[7:0];
  endfunction

  // Square of an 8-bit magnitude; at most 255*255 so 16 bits suffice.
  function automatic logic [15:0] sq8(input logic [7:0] a);
    return {8'd0, a} * {8'd0, a};
  endfunction

  state_t           r_state;
  logic             r_in_ready;
  logic             r_res_valid;
  logic [CNT_W-1:0] r_acc_cnt;
  logic [CNT_W-1:0] r_done_cnt;
  logic [ACC_W-1:0] r_sse;
  logic [ACC_W-1:0] r_mse;
  logic [7:0]       r_max_err;
  logic             r_sat;
  logic [15:0]      r_skip_cnt;
  logic             r_s1_valid;
  logic [8:0]       r_err;

  logic             w_accept;
  logic             w_arm;
  logic [CNT_W-1:0] w_acc_next;
  logic [7:0]       w_abs;
  logic [15:0]      w_sq;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;

  assign w_accept   = r_in_ready & i_in_valid;
  assign w_arm      = (r_state == ST_IDLE) & i_start;
  assign w_acc_next = r_acc_cnt + CNT_ONE;
  assign w_abs      = abs9(r_err);
  assign w_sq       = sq8(w_abs);
  assign w_sum      = {1'b0, r_sse} + {{(ACC_W-15){1'b0}}, w_sq};

`ifdef DIV_MSE_REM_EN
  logic [ACC_W-1:0] r_rem_sse;
  logic [ACC_W-1:0] r_rem_mse;
  logic [8:0]       r_rem_err;
  logic [7:0]       w_rem_abs;
  logic [15:0]      w_rem_sq;
  logic [ACC_W:0]   w_rem_sum;

  assign w_rem_abs = abs9(r_rem_err);
  assign w_rem_sq  = sq8(w_rem_abs);
  assign w_rem_sum = {1'b0, r_rem_sse} + {{(ACC_W-15){1'b0}}, w_rem_sq};
  assign w_ovf     = w_sum[ACC_W] | w_rem_sum[ACC_W];
  assign o_rem_sse = r_rem_sse;
  assign o_rem_mse = r_rem_mse;
`else
  assign w_ovf     = w_sum[ACC_W];
`endif

  // Run control: arm on start, count accepted samples, close the run and hold the result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_acc_cnt   <= {CNT_W{1'b0}};
      r_skip_cnt  <= 16'd0;
      r_mse       <= ACC_ZERO;
`ifdef DIV_MSE_REM_EN
      r_rem_mse   <= ACC_ZERO;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_RUN;
            r_in_ready <= 1'b1;
            r_acc_cnt  <= {CNT_W{1'b0}};
            r_skip_cnt <= 16'd0;
          end
        end
        ST_RUN: begin
          if (w_accept && i_d_zero) begin
            // Divide-by-zero samples are consumed but only counted as skipped.
            if (r_skip_cnt != 16'hFFFF) begin
              r_skip_cnt <= r_skip_cnt + 16'd1;
            end
          end else if (w_accept) begin
            r_acc_cnt <= w_acc_next;
            if (w_acc_next == N_SAMPLES) begin
              r_in_ready <= 1'b0;
              r_state    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Wait for the last sample to leave the pipeline before publishing.
          if (r_done_cnt == N_SAMPLES) begin
            r_state     <= ST_DONE;
            r_res_valid <= 1'b1;
            r_mse       <= r_sse >> LOG2_N;
`ifdef DIV_MSE_REM_EN
            r_rem_mse   <= r_rem_sse >> LOG2_N;
`endif
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here, even during the handshake.
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: register the signed error of each accepted, countable sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_err      <= 9'd0;
`ifdef DIV_MSE_REM_EN
      r_rem_err  <= 9'd0;
`endif
    end else begin
      r_s1_valid <= w_accept & ~i_d_zero;
      r_err      <= err9(i_q_exact, i_q_apx);
`ifdef DIV_MSE_REM_EN
      r_rem_err  <= err9(i_r_exact, i_r_apx);
`endif
    end
  end

  // Stage 2: saturating accumulation of squared error, running max, completion count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sse      <= ACC_ZERO;
      r_max_err  <= 8'd0;
      r_sat      <= 1'b0;
      r_done_cnt <= {CNT_W{1'b0}};
`ifdef DIV_MSE_REM_EN
      r_rem_sse  <= ACC_ZERO;
`endif
    end else if (w_arm) begin
      r_sse      <= ACC_ZERO;
      r_max_err  <= 8'd0;
      r_sat      <= 1'b0;
      r_done_cnt <= {CNT_W{1'b0}};
`ifdef DIV_MSE_REM_EN
      r_rem_sse  <= ACC_ZERO;
`endif
    end else if (r_s1_valid) begin
      r_done_cnt <= r_done_cnt + CNT_ONE;
      r_sse      <= w_sum[ACC_W] ? ACC_ONES : w_sum[ACC_W-1:0];
      r_sat      <= r_sat | w_ovf;
      if (w_abs > r_max_err) begin
        r_max_err <= w_abs;
      end
`ifdef DIV_MSE_REM_EN
      r_rem_sse  <= w_rem_sum[ACC_W] ? ACC_ONES : w_rem_sum[ACC_W-1:0];
`endif
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_res_valid = r_res_valid;
  assign o_sse       = r_sse;
  assign o_mse       = r_mse;
  assign o_max_err   = r_max_err;
  assign o_sat       = r_sat;
  assign o_skip_cnt  = r_skip_cnt;

endmodule

// File: tb/tb_div_mse_accumulator.sv
// Self-checking bench for div_mse_accumulator.
// DUT a: LOG2_N=2, ACC_W=17 (small enough to saturate). DUT b: LOG2_N=1, ACC_W=32.
module tb_div_mse_accumulator;
  localparam int    A_ACC = 17;
  localparam longint A_LIM = (64'd1 << A_ACC) - 1;
  localparam longint B_LIM = (64'd1 << 32) - 1;

  logic clk;
  logic rst;
  logic [7:0] q_apx, q_exact;
  logic d_zero;

  logic a_start, a_in_valid, a_res_ready, a_in_ready, a_res_valid, a_sat;
  logic [A_ACC-1:0] a_sse, a_mse;
  logic [7:0] a_max_err;
  logic [15:0] a_skip_cnt;

  logic b_start, b_in_valid, b_res_ready, b_in_ready, b_res_valid, b_sat;
  logic [31:0] b_sse, b_mse;
  logic [7:0] b_max_err;
  logic [15:0] b_skip_cnt;

`ifdef DIV_MSE_REM_EN
  logic [A_ACC-1:0] a_rem_sse, a_rem_mse;
  logic [31:0] b_rem_sse, b_rem_mse;
`endif

  int n_tests;
  int n_fail;
  int cyc;

  // behavioural reference: plain arithmetic over the accepted samples
  longint m_sse;
  int m_max;
  int m_skip;
  bit m_sat;

  logic [7:0] s_qe[$];
  logic [7:0] s_qa[$];
  bit s_dz[$];

  div_mse_accumulator #(.LOG2_N(2), .ACC_W(A_ACC)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_in_valid(a_in_valid),
    .o_in_ready(a_in_ready), .i_q_apx(q_apx), .i_q_exact(q_exact), .i_d_zero(d_zero),
`ifdef DIV_MSE_REM_EN
    .i_r_apx(8'd0), .i_r_exact(8'd0), .o_rem_sse(a_rem_sse), .o_rem_mse(a_rem_mse),
`endif
    .o_res_valid(a_res_valid), .i_res_ready(a_res_ready), .o_sse(a_sse), .o_mse(a_mse),
    .o_max_err(a_max_err), .o_sat(a_sat), .o_skip_cnt(a_skip_cnt)
  );

  div_mse_accumulator #(.LOG2_N(1), .ACC_W(32)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_in_valid(b_in_valid),
    .o_in_ready(b_in_ready), .i_q_apx(q_apx), .i_q_exact(q_exact), .i_d_zero(d_zero),
`ifdef DIV_MSE_REM_EN
    .i_r_apx(8'd0), .i_r_exact(8'd0), .o_rem_sse(b_rem_sse), .o_rem_mse(b_rem_mse),
`endif
    .o_res_valid(b_res_valid), .i_res_ready(b_res_ready), .o_sse(b_sse), .o_mse(b_mse),
    .o_max_err(b_max_err), .o_sat(b_sat), .o_skip_cnt(b_skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic m_clear();
    m_sse = 0; m_max = 0; m_skip = 0; m_sat = 1'b0;
  endtask

  task automatic m_add(input int qe, input int qa, input bit dz, input longint lim);
    int e;
    longint sq;
    if (dz) begin
      if (m_skip < 65535) m_skip++;
    end else begin
      e = qe - qa;
      sq = e * e;
      if (m_sse + sq > lim) begin
        m_sse = lim;
        m_sat = 1'b1;
      end else begin
        m_sse = m_sse + sq;
      end
      if (e < 0) e = -e;
      if (e > m_max) m_max = e;
    end
  endtask

  // present one sample to dut_a, waiting (bounded) for in_ready
  task automatic a_feed(input logic [7:0] qe, input logic [7:0] qa, input bit dz, output int t_acc);
    int waited;
    waited = 0;
    q_exact = qe; q_apx = qa; d_zero = dz; a_in_valid = 1'b1;
    while (a_in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    t_acc = cyc;
    if (a_in_ready !== 1'b1) begin
      n_tests++; n_fail++;
      $display("FAIL a_feed_ready: in_ready=%b, required 1 within 20 cycles", a_in_ready);
    end else begin
      m_add(qe, qa, dz, A_LIM);
      tick();
    end
    a_in_valid = 1'b0;
    d_zero = 1'b0;
  endtask

  // complete result checks against the model (dut_a)
  task automatic a_check(input string nm);
    logic [A_ACC-1:0] exp_sse;
    logic [A_ACC-1:0] exp_mse;
    exp_sse = m_sse[A_ACC-1:0];
    exp_mse = exp_sse >> 2;
    n_tests++;
    if (a_sse !== exp_sse) begin n_fail++; $display("FAIL %s_sse: got %0d, required %0d", nm, a_sse, exp_sse); end
    n_tests++;
    if (a_mse !== exp_mse) begin n_fail++; $display("FAIL %s_mse: got %0d, required %0d", nm, a_mse, exp_mse); end
    n_tests++;
    if (a_max_err !== 8'(m_max)) begin n_fail++; $display("FAIL %s_max_err: got %0d, required %0d", nm, a_max_err, m_max); end
    n_tests++;
    if (a_sat !== m_sat) begin n_fail++; $display("FAIL %s_sat: got %b, required %b", nm, a_sat, m_sat); end
    n_tests++;
    if (a_skip_cnt !== 16'(m_skip)) begin n_fail++; $display("FAIL %s_skip: got %0d, required %0d", nm, a_skip_cnt, m_skip); end
  endtask

  // one full run on dut_a from the s_* queues; leaves the result pending
  task automatic a_run(input string nm, input bit gaps);
    int t_last;
    logic rv1, rv2, rv3;
    m_clear();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int i = 0; i < s_qe.size(); i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      a_feed(s_qe[i], s_qa[i], s_dz[i], t_last);
    end
    rv1 = a_res_valid;
    n_tests++;
    if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL %s_ready_drop: in_ready=%b, required 0 after last sample", nm, a_in_ready); end
    tick();
    rv2 = a_res_valid;
    tick();
    rv3 = a_res_valid;
    n_tests++;
    if ({rv1, rv2, rv3} !== 3'b001) begin
      n_fail++;
      $display("FAIL %s_latency: res_valid in T+1..T+3 = %b%b%b, required 001", nm, rv1, rv2, rv3);
    end
    a_check(nm);
  endtask

  task automatic a_ack(input string nm);
    a_res_ready = 1'b1;
    tick();
    a_res_ready = 1'b0;
    n_tests++;
    if (a_res_valid !== 1'b0) begin n_fail++; $display("FAIL %s_ack: res_valid=%b, required 0", nm, a_res_valid); end
  endtask

  task automatic q_clear();
    s_qe.delete(); s_qa.delete(); s_dz.delete();
  endtask

  task automatic q_push(input logic [7:0] qe, input logic [7:0] qa, input bit dz);
    s_qe.push_back(qe); s_qa.push_back(qa); s_dz.push_back(dz);
  endtask

  // random samples until 4 countable ones are queued
  task automatic gen_random();
    int good;
    logic [7:0] qe, qa;
    q_clear();
    good = 0;
    while (good < 4) begin
      qe = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) qa = 8'($urandom_range(0, 255));
      else qa = qe ^ 8'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) begin
        q_push(qe, qa, 1'b1);
      end else begin
        q_push(qe, qa, 1'b0);
        good++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if ({a_in_ready, a_res_valid, a_sat, a_sse, a_mse, a_max_err, a_skip_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: rdy=%b rv=%b sat=%b sse=%0d mse=%0d max=%0d skip=%0d, required all 0",
               a_in_ready, a_res_valid, a_sat, a_sse, a_mse, a_max_err, a_skip_cnt);
    end
    n_tests++;
    if ({b_in_ready, b_res_valid, b_sat, b_sse, b_mse, b_max_err, b_skip_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: rdy=%b rv=%b sat=%b sse=%0d mse=%0d max=%0d skip=%0d, required all 0",
               b_in_ready, b_res_valid, b_sat, b_sse, b_mse, b_max_err, b_skip_cnt);
    end
  endtask

  task automatic test_zero_error();
    q_clear();
    repeat (4) q_push(8'd10, 8'd10, 1'b0);
    a_run("zero", 1'b0);
    a_ack("zero");
  endtask

  task automatic test_signed_errors();
    q_clear();
    q_push(8'd13, 8'd10, 1'b0);
    q_push(8'd7, 8'd10, 1'b0);
    q_push(8'd11, 8'd10, 1'b0);
    q_push(8'd10, 8'd10, 1'b0);
    a_run("signed", 1'b0);
    n_tests++;
    if (a_sse !== 17'd19 || a_mse !== 17'd4 || a_max_err !== 8'd3 || a_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_const: sse=%0d mse=%0d max=%0d sat=%b, required 19 4 3 0", a_sse, a_mse, a_max_err, a_sat);
    end
    a_ack("signed");
  endtask

  task automatic test_saturation();
    q_clear();
    repeat (4) q_push(8'd255, 8'd0, 1'b0);
    a_run("sat", 1'b1);
    n_tests++;
    if (a_sat !== 1'b1 || a_sse !== 17'h1FFFF) begin
      n_fail++;
      $display("FAIL sat_const: sat=%b sse=%h, required 1 1ffff", a_sat, a_sse);
    end
    a_ack("sat");
  endtask

  task automatic test_skip_b();
    bit rdy_ok;
    logic rv1, rv2, rv3;
    m_clear();
    rdy_ok = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_in_valid = 1'b1;
    q_exact = 8'd20; q_apx = 8'd15; d_zero = 1'b0;
    if (b_in_ready !== 1'b1) rdy_ok = 1'b0;
    m_add(20, 15, 1'b0, B_LIM);
    tick();
    q_exact = 8'd99; q_apx = 8'd3; d_zero = 1'b1;
    if (b_in_ready !== 1'b1) rdy_ok = 1'b0;
    m_add(99, 3, 1'b1, B_LIM);
    tick();
    q_exact = 8'd9; q_apx = 8'd12; d_zero = 1'b0;
    if (b_in_ready !== 1'b1) rdy_ok = 1'b0;
    m_add(9, 12, 1'b0, B_LIM);
    tick();
    b_in_valid = 1'b0;
    d_zero = 1'b0;
    n_tests++;
    if (!rdy_ok) begin n_fail++; $display("FAIL skip_stream: in_ready dropped during 3 continuous samples, required 1"); end
    rv1 = b_res_valid;
    n_tests++;
    if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL skip_ready_drop: in_ready=%b, required 0", b_in_ready); end
    tick();
    rv2 = b_res_valid;
    tick();
    rv3 = b_res_valid;
    n_tests++;
    if ({rv1, rv2, rv3} !== 3'b001) begin n_fail++; $display("FAIL skip_latency: res_valid = %b%b%b, required 001", rv1, rv2, rv3); end
    n_tests++;
    if (b_sse !== m_sse[31:0] || b_mse !== m_sse[32:1] || b_max_err !== 8'(m_max) || b_sat !== m_sat) begin
      n_fail++;
      $display("FAIL skip_result: sse=%0d mse=%0d max=%0d sat=%b, required %0d %0d %0d %b",
               b_sse, b_mse, b_max_err, b_sat, m_sse, m_sse >> 1, m_max, m_sat);
    end
    n_tests++;
    if (b_skip_cnt !== 16'd1 || b_sse !== 32'd34) begin
      n_fail++;
      $display("FAIL skip_const: skip=%0d sse=%0d, required 1 34", b_skip_cnt, b_sse);
    end
    b_res_ready = 1'b1;
    tick();
    b_res_ready = 1'b0;
    n_tests++;
    if (b_res_valid !== 1'b0) begin n_fail++; $display("FAIL skip_ack: res_valid=%b, required 0", b_res_valid); end
  endtask

  task automatic test_hold_and_ignore_start();
    gen_random();
    a_run("hold", 1'b1);
    for (int i = 0; i < 10; i++) begin
      a_start = (i % 2 == 0);
      tick();
      a_check("hold_stable");
      n_tests++;
      if (a_res_valid !== 1'b1 || a_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_flags: cycle %0d res_valid=%b in_ready=%b, required 1 0", i, a_res_valid, a_in_ready);
      end
    end
    a_start = 1'b1;
    a_res_ready = 1'b1;
    tick();
    a_start = 1'b0;
    a_res_ready = 1'b0;
    n_tests++;
    if (a_res_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_handshake: res_valid=%b in_ready=%b, required 0 0", a_res_valid, a_in_ready);
    end
    tick();
    n_tests++;
    if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_start_ignored: in_ready=%b, required 0", a_in_ready); end
    a_check("hold_idle_keep");
    gen_random();
    a_run("after_hold", 1'b1);
    a_ack("after_hold");
  endtask

  task automatic test_reset_mid_run();
    int t;
    bit bad;
    m_clear();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_feed(8'd200, 8'd100, 1'b0, t);
    a_feed(8'd50, 8'd60, 1'b0, t);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({a_in_ready, a_res_valid, a_sat, a_sse, a_mse, a_max_err, a_skip_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midrst_outputs: rdy=%b rv=%b sat=%b sse=%0d mse=%0d max=%0d skip=%0d, required all 0",
               a_in_ready, a_res_valid, a_sat, a_sse, a_mse, a_max_err, a_skip_cnt);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (a_res_valid !== 1'b0 || a_in_ready !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin n_fail++; $display("FAIL midrst_no_result: res_valid/in_ready rose after reset, required 0"); end
    gen_random();
    a_run("after_rst", 1'b1);
    a_ack("after_rst");
  endtask

  task automatic test_random_runs();
    for (int r = 0; r < 8; r++) begin
      gen_random();
      a_run("rand", 1'b1);
      repeat ($urandom_range(0, 3)) tick();
      a_ack("rand");
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    q_apx = 8'd0; q_exact = 8'd0; d_zero = 1'b0;
    a_start = 1'b0; a_in_valid = 1'b0; a_res_ready = 1'b0;
    b_start = 1'b0; b_in_valid = 1'b0; b_res_ready = 1'b0;
    test_reset();
    test_zero_error();
    test_signed_errors();
    test_skip_b();
    test_saturation();
    test_hold_and_ignore_start();
    test_reset_mid_run();
    test_random_runs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
